regfile_writeback: RTL and testbench

- Writer side of the register-file write port (wr_en / wr_add / wr_data).
- Accepts retiring results from the ALU and the load unit over valid/ready handshakes.
- Performs load byte/halfword extraction, queues pending writes in a small FIFO, and drains one write per cycle into the register file.
- Provides a pending-destination lookup for the issue-stage stall logic.

---
 rtl/regfile_writeback.sv | 115 +++++++++++
 tb/tb_regfile_writeback.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writer: merges ALU and load results through a small FIFO
// and retires one register write per cycle, with a pending-destination lookup.
module regfile_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_word,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  output logic            wr_en,
  output logic [AW-1:0]   wr_add,
  output logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   chk_add,
  output logic            pending_hit,
  output logic [CW-1:0]   count,
  output logic            err
);

  function automatic logic ld_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic [XLEN-1:0] ld_extract(input logic [XLEN-1:0] word,
                                                 input logic [2:0]      f3,
                                                 input logic [1:0]      off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return '0;
    endcase
  endfunction

  logic [AW-1:0]   mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [PW-1:0]   head, tail, idx;
  logic            not_full, ld_fire, alu_fire, push, pop, hit, legal;
  logic [AW-1:0]   push_rd;
  logic [XLEN-1:0] push_data;

  // Readies come from registered count only; a full FIFO never pushes through.
  assign not_full  = count < CW'(DEPTH);
  assign ld_ready  = rst && not_full;
  assign alu_ready = rst && not_full && !ld_valid;
  assign ld_fire   = ld_valid && ld_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign legal     = ld_legal(ld_funct3);
  assign push_rd   = ld_fire ? ld_rd : alu_rd;
  assign push_data = ld_fire ? ld_extract(ld_word, ld_funct3, ld_off) : alu_data;
  assign push      = (ld_fire && legal && (ld_rd != '0)) || (alu_fire && (alu_rd != '0));
  assign pop       = count != '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[tail]   <= push_rd;
      mem_data[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_add  <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      err <= ld_fire && !legal;
      if (push) tail <= tail + PW'(1);
      if (pop) begin
        head    <= head + PW'(1);
        wr_en   <= 1'b1;
        wr_add  <= mem_rd[head];
        wr_data <= mem_data[head];
      end else begin
        wr_en <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Walk the occupied slots from head; the retiring write also counts as pending.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (mem_rd[idx] == chk_add)) hit = 1'b1;
    end
  end

  assign pending_hit = (chk_add != '0) && (hit || (wr_en && (wr_add == chk_add)));

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle,
// a table of load-extraction vectors, and directed multi-cycle sequences.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd, wr_add, chk_add;
  logic [31:0] alu_data, ld_word, wr_data;
  logic [2:0]  ld_funct3, count;
  logic [1:0]  ld_off;
  logic        wr_en, pending_hit, err;

  regfile_writeback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_word(ld_word),
    .ld_funct3(ld_funct3), .ld_off(ld_off),
    .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .chk_add(chk_add), .pending_hit(pending_hit), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of pending (rd, data) plus the retiring write.
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  logic        m_wr_en = 1'b0, m_err = 1'b0, m_acc_alu = 1'b0;
  logic [4:0]  m_wr_add = '0;
  logic [31:0] m_wr_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_legal(input logic [2:0] f3);
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // Called #1 after an edge with inputs already set; advances one clock.
  task automatic tick();
    logic exp_ldr, exp_alur, ldf, aluf, hitm;
    #1;
    exp_ldr  = rst && (q_rd.size() < DEPTH);
    exp_alur = exp_ldr && !ld_valid;
    check("ld_ready", ld_ready, exp_ldr);
    check("alu_ready", alu_ready, exp_alur);
    ldf  = ld_valid && exp_ldr;
    aluf = alu_valid && exp_alur;
    m_acc_alu = aluf;
    if (!rst) begin
      q_rd.delete();
      q_data.delete();
      m_wr_en = 0; m_wr_add = 0; m_wr_data = 0; m_err = 0;
    end else begin
      if (q_rd.size() > 0) begin
        m_wr_en = 1;
        m_wr_add = q_rd.pop_front();
        m_wr_data = q_data.pop_front();
      end else begin
        m_wr_en = 0;
      end
      m_err = ldf && !m_legal(ld_funct3);
      if (ldf && m_legal(ld_funct3) && ld_rd != 0) begin
        q_rd.push_back(ld_rd);
        q_data.push_back(m_load(ld_word, ld_funct3, ld_off));
      end else if (aluf && alu_rd != 0) begin
        q_rd.push_back(alu_rd);
        q_data.push_back(alu_data);
      end
    end
    @(posedge clk);
    #1;
    hitm = 0;
    foreach (q_rd[i]) if (q_rd[i] == chk_add) hitm = 1;
    if (m_wr_en && m_wr_add == chk_add) hitm = 1;
    hitm = hitm && (chk_add != 0);
    check("count", count, q_rd.size());
    check("wr_en", wr_en, m_wr_en);
    check("wr_add", wr_add, m_wr_add);
    check("wr_data", wr_data, m_wr_data);
    check("err", err, m_err);
    check("pending_hit", pending_hit, hitm);
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp_data;
    logic        writes;
  } ld_vec_t;

  ld_vec_t vecs[7];
  logic [4:0] seen[$];

  initial begin
    vecs[0] = '{3'b000, 2'd0, 32'h0000_0032, 1'b1};
    vecs[1] = '{3'b000, 2'd2, 32'hFFFF_FFF1, 1'b1};
    vecs[2] = '{3'b100, 2'd3, 32'h0000_0080, 1'b1};
    vecs[3] = '{3'b001, 2'd2, 32'hFFFF_80F1, 1'b1};
    vecs[4] = '{3'b101, 2'd0, 32'h0000_7F32, 1'b1};
    vecs[5] = '{3'b010, 2'd1, 32'h80F1_7F32, 1'b1};
    vecs[6] = '{3'b011, 2'd0, 32'h0000_0000, 1'b0};

    rst = 0; alu_valid = 1; ld_valid = 1; alu_rd = 5'd4; ld_rd = 5'd9;
    alu_data = 32'h11; ld_word = 32'h22; ld_funct3 = 3'b010; ld_off = 0; chk_add = 0;
    @(posedge clk); #1;

    // Reset held with both valids offered.
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_ld_ready", ld_ready, 0);
    rst = 1; idle();
    tick();
    check("rel_count", count, 0);

    // Single ALU result: write visible only after the following edge.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'd64;
    tick();
    check("alu_lat_early", wr_en, 0);
    idle();
    tick();
    check("alu_wr_en", wr_en, 1);
    check("alu_wr_add", wr_add, 3);
    check("alu_wr_data", wr_data, 64);
    tick();
    check("alu_wr_off", wr_en, 0);

    // Load extraction table.
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1; ld_rd = 5'd10; ld_word = 32'h80F1_7F32;
      ld_funct3 = vecs[i].f3; ld_off = vecs[i].off;
      tick();
      check($sformatf("ld%0d_err", i), err, !vecs[i].writes);
      idle();
      tick();
      check($sformatf("ld%0d_wr_en", i), wr_en, vecs[i].writes);
      if (vecs[i].writes) check($sformatf("ld%0d_data", i), wr_data, vecs[i].exp_data);
      else check($sformatf("ld%0d_err_clear", i), err, 0);
      tick();
    end

    // Priority: load wins, ALU follows; pending lookup on rd 13.
    ld_valid = 1; ld_rd = 5'd13; ld_funct3 = 3'b010; ld_word = 32'd76; ld_off = 0;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'd5; chk_add = 5'd13;
    #1;
    check("prio_alu_ready", alu_ready, 0);
    tick();
    check("pend_queued", pending_hit, 1);
    ld_valid = 0;
    tick();
    check("prio_first_add", wr_add, 13);
    check("prio_first_data", wr_data, 76);
    check("pend_writing", pending_hit, 1);
    alu_valid = 0;
    tick();
    check("prio_second_add", wr_add, 7);
    check("prio_second_data", wr_data, 5);
    check("pend_gone", pending_hit, 0);
    chk_add = 0;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    tick();
    check("x0_count", count, 0);
    check("x0_pend", pending_hit, 0);
    idle();
    tick();
    check("x0_no_write", wr_en, 0);

    // Six back-to-back ALU pushes: in-order, no loss, pointers wrap.
    seen.delete();
    for (int i = 1; i <= 6; i++) begin
      int guard;
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'(100 + i);
      guard = 0;
      do begin
        tick();
        if (wr_en) seen.push_back(wr_add);
        guard++;
      end while (!m_acc_alu && guard < 20);
      if (!m_acc_alu) check("burst_accept_timeout", 0, 1);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_en) seen.push_back(wr_add);
    end
    check("burst_nwrites", seen.size(), 6);
    foreach (seen[i]) check($sformatf("burst_order%0d", i), seen[i], i + 1);

    // Reset while a write is queued: discarded, nothing written afterwards.
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    check("mid_queued", count, 1);
    idle(); rst = 0;
    tick();
    check("mid_count", count, 0);
    check("mid_wr_en", wr_en, 0);
    rst = 1;
    tick();
    check("mid_after", wr_en, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) != 0);
      alu_valid = $urandom_range(0, 1);
      ld_valid  = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      ld_rd     = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_word   = $urandom;
      ld_funct3 = 3'($urandom_range(0, 7));
      ld_off    = 2'($urandom_range(0, 3));
      chk_add   = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1; idle();
    for (int i = 0; i < 4; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
